pci_noc_packetizer: RTL and testbench

Upstream feeder for a PE's NoC injection port. It accepts 256-bit PCI stream beats: first a command beat naming a destination router and a word count, then that many payload words. Each payload word is sliced into four 64-bit flits, tagged with the destination X/Y, and presented on a valid/ready flit interface to the NoC switch. A running count of flits sent is also exposed.

---
 rtl/pci_noc_packetizer_pkg.sv | 24 ++
 rtl/pci_noc_packetizer.sv | 101 ++++++++++
 tb/tb_pci_noc_packetizer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_noc_packetizer_pkg.sv
// Shared definitions for the PCI-to-NoC packetizer: flit geometry, command
// beat field offsets and FSM state encoding used by the switch and PE blocks.
package pci_noc_packetizer_pkg;

    localparam int PCI_W          = 256;
    localparam int X_W            = 4;
    localparam int Y_W            = 4;
    localparam int FLIT_PAYLOAD_W = 64;
    localparam int FLIT_W         = FLIT_PAYLOAD_W + X_W + Y_W;
    localparam int FLITS_PER_WORD = PCI_W / FLIT_PAYLOAD_W;

    // command beat: dest_x at bit 0, dest_y right above it, word count in [31:16]
    localparam int CMD_X_LSB   = 0;
    localparam int CMD_Y_LSB   = X_W;
    localparam int CMD_CNT_LSB = 16;
    localparam int CMD_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_e;

endpackage

// File: rtl/pci_noc_packetizer.sv
// Turns a PCI command beat plus N 256-bit payload beats into X/Y-tagged
// flits on a valid/ready NoC injection port, lowest payload slice first.
module pci_noc_packetizer
    import pci_noc_packetizer_pkg::*;
#(
    parameter int X_W            = pci_noc_packetizer_pkg::X_W,
    parameter int Y_W            = pci_noc_packetizer_pkg::Y_W,
    parameter int FLIT_PAYLOAD_W = pci_noc_packetizer_pkg::FLIT_PAYLOAD_W,
    parameter int FLIT_W         = FLIT_PAYLOAD_W + X_W + Y_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid_pci,
    input  logic [255:0]      i_data_pci,
    output logic              o_ready_pci,
    output logic [FLIT_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic [31:0]       o_flit_count
);

    localparam int FPW   = 256 / FLIT_PAYLOAD_W;
    localparam int IDX_W = (FPW > 1) ? $clog2(FPW) : 1;

    state_e                   state, state_n;
    logic [X_W-1:0]           dest_x;
    logic [Y_W-1:0]           dest_y;
    logic [CMD_CNT_W-1:0]     words_left;
    logic [IDX_W-1:0]         flit_idx;
    logic [255:0]             word;

    logic                     pci_fire, flit_fire, last_flit;
    logic [CMD_CNT_W-1:0]     cmd_cnt;
    logic [IDX_W-1:0]         nxt_idx;
    logic [255:0]             word_sh;
    logic [FLIT_PAYLOAD_W-1:0] nxt_payload;

    assign pci_fire  = i_valid_pci & o_ready_pci;
    assign flit_fire = o_valid & i_ready;
    assign last_flit = (flit_idx == IDX_W'(FPW - 1));
    assign cmd_cnt   = i_data_pci[CMD_CNT_LSB +: CMD_CNT_W];
    assign nxt_idx   = flit_idx + 1'b1;
    assign o_busy    = (state != ST_IDLE);

    always_comb begin
        word_sh     = word >> (nxt_idx * FLIT_PAYLOAD_W);
        nxt_payload = word_sh[FLIT_PAYLOAD_W-1:0];
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (pci_fire && cmd_cnt != '0) state_n = ST_LOAD;
            ST_LOAD: if (pci_fire) state_n = ST_SEND;
            ST_SEND: if (flit_fire && last_flit)
                         state_n = (words_left == CMD_CNT_W'(1)) ? ST_IDLE : ST_LOAD;
            default: state_n = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from next state so flit 0 is valid on
    // the same edge its payload beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            dest_x       <= '0;
            dest_y       <= '0;
            words_left   <= '0;
            flit_idx     <= '0;
            word         <= '0;
            o_ready_pci  <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_flit_count <= '0;
        end else begin
            state       <= state_n;
            o_ready_pci <= (state_n != ST_SEND);
            o_valid     <= (state_n == ST_SEND);
            if (state == ST_IDLE && pci_fire) begin
                dest_x     <= i_data_pci[CMD_X_LSB +: X_W];
                dest_y     <= i_data_pci[CMD_Y_LSB +: Y_W];
                words_left <= cmd_cnt;
            end
            if (state == ST_LOAD && pci_fire) begin
                word     <= i_data_pci;
                flit_idx <= '0;
                o_data   <= {dest_y, dest_x, i_data_pci[FLIT_PAYLOAD_W-1:0]};
            end
            if (flit_fire) begin
                o_flit_count <= o_flit_count + 32'd1;
                flit_idx     <= nxt_idx;
                if (last_flit)
                    words_left <= words_left - 1'b1;
                else
                    o_data <= {dest_y, dest_x, nxt_payload};
            end
        end
    end

endmodule

// File: tb/tb_pci_noc_packetizer.sv
// Randomized bench for pci_noc_packetizer: a queue of expected flits built
// from issued commands is checked against every flit handshake.
module tb_pci_noc_packetizer;

    localparam int X_W = 4;
    localparam int Y_W = 4;
    localparam int PW  = 64;
    localparam int FW  = PW + X_W + Y_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid_pci = 1'b0;
    logic [255:0]  i_data_pci = '0;
    logic          o_ready_pci;
    logic [FW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          o_busy;
    logic [31:0]   o_flit_count;

    pci_noc_packetizer dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid_pci  (i_valid_pci),
        .i_data_pci   (i_data_pci),
        .o_ready_pci  (o_ready_pci),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_flit_count (o_flit_count)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] got_q[$];
    logic [31:0]   exp_cnt = '0;
    bit            rnd_rdy = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // switch-side backpressure
    initial forever begin
        @(posedge clk); #1;
        i_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // compare process: sampled on the falling edge, ahead of the next handshake edge
    initial begin
        logic          prev_stall;
        logic [FW-1:0] prev_data;
        logic [FW-1:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                check("flit_count", o_flit_count, exp_cnt);
                if (prev_stall) begin
                    check("stall_valid_hold", o_valid, 1'b1);
                    check("stall_data_hold", o_data, prev_data);
                end
                if (o_valid) begin
                    check("ready_pci_in_send", o_ready_pci, 1'b0);
                    check("busy_in_send", o_busy, 1'b1);
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_flit");
                    else begin
                        e = exp_q.pop_front();
                        check("flit_data", o_data, e);
                    end
                    got_q.push_back(o_data);
                    exp_cnt = exp_cnt + 32'd1;
                end
                prev_stall = o_valid && !i_ready;
                prev_data  = o_data;
            end
        end
    end

    function automatic logic [255:0] mk_cmd(input logic [3:0] x, input logic [3:0] y,
                                            input logic [15:0] cnt);
        logic [255:0] c;
        for (int i = 0; i < 8; i++) c[i*32 +: 32] = $urandom;
        c[3:0]   = x;
        c[7:4]   = y;
        c[31:16] = cnt;
        return c;
    endfunction

    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // caller sits just after a rising edge; returns just after the accepting edge
    task automatic send_beat(input logic [255:0] d);
        int n;
        i_valid_pci = 1'b1;
        i_data_pci  = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_ready_pci && n < 1000);
        if (n >= 1000) fail_now("beat_accept_timeout");
        @(posedge clk); #1;
        i_valid_pci = 1'b0;
    endtask

    task automatic do_word(input logic [3:0] x, input logic [3:0] y, input logic [255:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back({y, x, w[k*PW +: PW]});
        send_beat(w);
    endtask

    task automatic do_cmd(input logic [3:0] x, input logic [3:0] y, input int cnt);
        send_beat(mk_cmd(x, y, 16'(cnt)));
        for (int i = 0; i < cnt; i++) do_word(x, y, rnd_word());
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid || o_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] base;
        int          g0, n;

        // reset values
        #2;
        check("rst_ready_pci", o_ready_pci, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, '0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_flit_count", o_flit_count, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", o_ready_pci, 1'b1);

        // single word to (3,5), slices 1..4
        got_q.delete();
        send_beat(mk_cmd(4'd3, 4'd5, 16'd1));
        do_word(4'd3, 4'd5, {64'd4, 64'd3, 64'd2, 64'd1});
        wait_idle();
        check("t1_nflits", got_q.size(), 4);
        check("t1_f0", got_q[0], {4'd5, 4'd3, 64'd1});
        check("t1_f1", got_q[1], {4'd5, 4'd3, 64'd2});
        check("t1_f2", got_q[2], {4'd5, 4'd3, 64'd3});
        check("t1_f3", got_q[3], {4'd5, 4'd3, 64'd4});
        check("t1_ready_pci", o_ready_pci, 1'b1);
        check("t1_count", o_flit_count, 32'd4);

        // zero-count command
        send_beat(mk_cmd(4'd7, 4'd2, 16'd0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cnt0_busy", o_busy, 1'b0);
            check("cnt0_valid", o_valid, 1'b0);
        end
        @(posedge clk); #1;
        check("cnt0_count", o_flit_count, 32'd4);

        // count=3 under random backpressure
        rnd_rdy = 1'b1;
        got_q.delete();
        do_cmd(4'd9, 4'd12, 3);
        wait_idle();
        check("t3_nflits", got_q.size(), 12);

        // back-to-back commands
        rnd_rdy = 1'b0;
        base = o_flit_count;
        got_q.delete();
        do_cmd(4'd1, 4'd1, 2);
        do_cmd(4'd2, 4'd0, 1);
        wait_idle();
        check("b2b_nflits", got_q.size(), 12);
        check("b2b_tag_first", got_q[7][FW-1:PW], {4'd1, 4'd1});
        check("b2b_tag_last", got_q[8][FW-1:PW], {4'd0, 4'd2});
        check("b2b_count", o_flit_count, base + 32'd12);

        // random commands
        rnd_rdy = 1'b1;
        for (int t = 0; t < 6; t++)
            do_cmd(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        wait_idle();

        // reset after flit 1 of a 2-word command
        rnd_rdy = 1'b0;
        send_beat(mk_cmd(4'd6, 4'd9, 16'd2));
        g0 = got_q.size();
        do_word(4'd6, 4'd9, rnd_word());
        n = 0;
        while (got_q.size() < g0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("mid_rst_wait_timeout");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mrst_ready_pci", o_ready_pci, 1'b0);
        check("mrst_valid", o_valid, 1'b0);
        check("mrst_data", o_data, '0);
        check("mrst_busy", o_busy, 1'b0);
        check("mrst_count", o_flit_count, '0);
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_ready_after", o_ready_pci, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mrst_no_stale", o_valid, 1'b0);
        end
        @(posedge clk); #1;
        got_q.delete();
        do_cmd(4'd4, 4'd8, 1);
        wait_idle();
        check("mrst_fresh_nflits", got_q.size(), 4);
        check("mrst_fresh_count", o_flit_count, 32'd4);

        // counter wrap
        #2;
        force dut.o_flit_count = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.o_flit_count;
        @(posedge clk); #1;
        do_cmd(4'd5, 4'd5, 1);
        wait_idle();
        check("wrap_count", o_flit_count, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
